spi_master_xfer: RTL and testbench
==================================

SPI_MASTER_XFER -- requirements
Module: spi_master_xfer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  transfer request, sampled only when busy=0.
REQ-005 SHALL have port cmd  input  8  command byte; bit7 = write enable, bits[2:0] = target address.
REQ-006 SHALL have port data_len  input  3  payload bytes following cmd, 0..4.
REQ-007 SHALL have port wr_data  input  32  payload to send, right-aligned.
REQ-008 SHALL have port rd_data  output  32  payload received, right-aligned.
REQ-009 SHALL have port status_byte  output  8  byte received during cmd (device ID|version).
REQ-010 SHALL have port busy  output  1  transfer or inter-frame gap in progress.
REQ-011 SHALL have port done  output  1  one-cycle strobe at end of frame.
REQ-012 SHALL have port ncs_spi  output  1  chip select, active-low.
REQ-013 SHALL have port sck_spi  output  1  serial clock, idle low.
REQ-014 SHALL have port mosi_spi  output  1  serial data out.
REQ-015 SHALL have port miso_spi  input  1  serial data in.

Function
REQ-016 SHALL use states IDLE, SHIFT, HOLD, GAP; IDLE->SHIFT on start; SHIFT->HOLD after last SCK fall; HOLD->GAP after CLK_DIV cycles; GAP->IDLE after CLK_DIV cycles.
REQ-017 SHALL, on start in IDLE, latch cmd, data_len, wr_data; set B = 8 + 8*L, where L = min(data_len,4).
REQ-018 SHALL, with start accepted at cycle 0, drive ncs_spi=0 and mosi_spi=cmd[7] from cycle 1.
REQ-019 SHALL generate SCK (mode 0): rise at cycle 1+(2k+1)*CLK_DIV, fall at 1+(2k+2)*CLK_DIV, for bit k = 0..B-1.
REQ-020 SHALL sample miso_spi on each SCK rise; SHALL update mosi_spi to the next bit on each SCK fall except the last.
REQ-021 SHALL shift MSB first: cmd[7:0], then wr_data[8L-1:0].
REQ-022 SHALL load the bits sampled during bits 0..7 into status_byte, and the bits sampled during bits 8..B-1 into rd_data[8L-1:0], with rd_data[31:8L] = 0.
REQ-023 SHALL hold rd_data and status_byte stable from done until the next accepted start.
REQ-024 SHALL drive ncs_spi=1 and pulse done for exactly one cycle at cycle 1+(2B+1)*CLK_DIV.
REQ-025 SHALL drive busy=1 from cycle 1 through GAP and deassert it at cycle 1+(2B+2)*CLK_DIV.
REQ-026 SHALL ignore start while busy=1, with no effect on any state.
REQ-027 SHALL treat data_len 5..7 as 4.
REQ-028 SHALL, for data_len=0, send the 8-bit command only and leave rd_data=0.
REQ-029 SHALL accept a start asserted in the same cycle busy falls only from the next cycle.
REQ-030 SHALL hold sck_spi low whenever ncs_spi=1.

Reset
REQ-031 SHALL, on rst, immediately force state IDLE, ncs_spi=1, sck_spi=0, mosi_spi=0, busy=0, done=0, rd_data=0, status_byte=0, and clear all counters.
REQ-032 SHALL abort a transfer on rst mid-frame without a done pulse; ncs_spi SHALL go high asynchronously.
REQ-033 SHALL accept a new start on the first clock edge after rst deasserts.

Verification
REQ-034 Write, CLK_DIV=2: cmd=0x80, data_len=4, wr_data=0xDEADBEEF, slave returns 0x91 -> MOSI stream 80 DE AD BE EF, status_byte=0x91, 40 SCK pulses, done at cycle 163, busy falls at cycle 165.
REQ-035 Read: cmd=0x02, data_len=4, slave returns 0x91 then 0x12345678 -> rd_data=0x12345678, status_byte=0x91.
REQ-036 Short read: data_len=2, slave payload 0x1234 -> rd_data=0x00001234; data_len=0, CLK_DIV=2 -> 8 SCK pulses, done at cycle 35, rd_data=0.
REQ-037 Start pulsed at cycle 10 of an active frame with cmd=0xFF -> ignored, frame completes unchanged; data_len=7 -> 40-bit frame.
REQ-038 rst asserted between the 12th SCK rise and fall -> ncs_spi=1 and sck_spi=0 same cycle, no done, busy=0; next start runs a clean frame.
REQ-039 CLK_DIV=1, data_len=1 -> SCK toggles every cycle, 16 pulses, done at cycle 34, back-to-back start accepted at cycle 36.

Source files
------------

// File: rtl/spi_master_xfer.sv
// spi_master_xfer
//   SPI mode-0 master that shifts one frame: an 8-bit command byte followed by
//   0..4 payload bytes, MSB first. The byte clocked in during the command is
//   kept as status_byte; the bytes clocked in during the payload are kept,
//   right-aligned, in rd_data. Each frame ends with a HOLD of one SCK half
//   period (chip select still low) and a GAP of one half period (chip select
//   high, still busy).
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start             : frame request, only honoured in IDLE
//   cmd               : command byte (bit7 write enable, bits[2:0] address)
//   data_len          : payload byte count, values above 4 act as 4
//   wr_data           : payload to send, right-aligned
//   rd_data           : payload received, right-aligned, upper bytes zero
//   status_byte       : byte received while the command was shifted
//   busy              : frame or inter-frame gap in progress
//   done              : one-cycle strobe when chip select rises
//   ncs_spi, sck_spi,
//   mosi_spi, miso_spi: SPI pins
module spi_master_xfer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [2:0]  data_len,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  status_byte,
  output logic        busy,
  output logic        done,
  output logic        ncs_spi,
  output logic        sck_spi,
  output logic        mosi_spi,
  input  logic        miso_spi
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2, GAP = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  div_cnt_reg;
  logic        div_tick;
  logic [6:0]  edge_cnt_reg;
  logic [6:0]  last_edge;
  logic [2:0]  len_reg;
  logic [2:0]  len_clamped;
  logic [5:0]  pay_bits;
  logic        sck_reg;
  logic        ready_reg;
  logic        start_ok;
  logic [39:0] tx_sr_reg;
  logic [39:0] rx_sr_reg;
  logic [31:0] rd_data_reg;
  logic [7:0]  status_reg;

  // One tick per SCK half period.
  assign div_tick    = (div_cnt_reg == 8'(CLK_DIV - 1));
  // Frame has 2*B SCK edges, B = 8 + 8*len; the last one is 15 + 16*len.
  assign last_edge   = 7'd15 + {len_reg, 4'b0000};
  assign len_clamped = (data_len > 3'd4) ? 3'd4 : data_len;
  assign pay_bits    = {len_reg, 3'b000};
  // ready_reg is low for the first IDLE cycle after a GAP, so a start seen
  // in the cycle busy falls is only taken one cycle later.
  assign start_ok    = start && ready_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start_ok) state_next = SHIFT;
      SHIFT: if (div_tick && edge_cnt_reg == last_edge) state_next = HOLD;
      HOLD:  if (div_tick) state_next = GAP;
      GAP:   if (div_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: divider, edge counter, shift registers, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      len_reg      <= '0;
      sck_reg      <= 1'b0;
      ready_reg    <= 1'b1;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
      rd_data_reg  <= '0;
      status_reg   <= '0;
    end else begin
      ready_reg   <= (state_reg != GAP);
      div_cnt_reg <= (state_reg == IDLE || div_tick) ? 8'd0 : div_cnt_reg + 8'd1;
      unique case (state_reg)
        IDLE: begin
          if (start_ok) begin
            len_reg      <= len_clamped;
            // Payload left-aligned behind the command; a shift of 32 yields 0.
            tx_sr_reg    <= {cmd, wr_data << (6'd32 - {len_clamped, 3'b000})};
            rx_sr_reg    <= '0;
            edge_cnt_reg <= '0;
            sck_reg      <= 1'b0;
          end
        end
        SHIFT: begin
          if (div_tick) begin
            edge_cnt_reg <= edge_cnt_reg + 7'd1;
            if (!sck_reg) begin
              sck_reg   <= 1'b1;
              rx_sr_reg <= {rx_sr_reg[38:0], miso_spi};
            end else begin
              sck_reg <= 1'b0;
              // Keep the final bit on MOSI through HOLD.
              if (edge_cnt_reg != last_edge) tx_sr_reg <= {tx_sr_reg[38:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (div_tick) begin
            // rx_sr holds B bits right-aligned: status above 8*len payload bits.
            rd_data_reg <= rx_sr_reg[31:0] & ~(32'hFFFF_FFFF << pay_bits);
            status_reg  <= 8'(rx_sr_reg >> pay_bits);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    ncs_spi     = !(state_reg == SHIFT || state_reg == HOLD);
    busy        = (state_reg != IDLE);
    done        = (state_reg == GAP) && (div_cnt_reg == 8'd0);
    sck_spi     = sck_reg && (state_reg == SHIFT);
    mosi_spi    = (state_reg == SHIFT || state_reg == HOLD) ? tx_sr_reg[39] : 1'b0;
    rd_data     = rd_data_reg;
    status_byte = status_reg;
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
module tb_spi_master_xfer;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic        clk;
  logic        rst_a   [2];
  logic        start_a [2];
  logic        miso_a  [2];
  logic [7:0]  cmd_a   [2];
  logic [2:0]  len_a   [2];
  logic [31:0] wd_a    [2];
  logic [31:0] rd_a    [2];
  logic [7:0]  st_a    [2];
  logic        busy_a  [2];
  logic        done_a  [2];
  logic        ncs_a   [2];
  logic        sck_a   [2];
  logic        mosi_a  [2];

  int n_tests = 0;
  int n_fail  = 0;

  spi_master_xfer #(.CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .cmd(cmd_a[0]),
    .data_len(len_a[0]), .wr_data(wd_a[0]), .rd_data(rd_a[0]),
    .status_byte(st_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .ncs_spi(ncs_a[0]), .sck_spi(sck_a[0]), .mosi_spi(mosi_a[0]),
    .miso_spi(miso_a[0])
  );

  spi_master_xfer #(.CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .cmd(cmd_a[1]),
    .data_len(len_a[1]), .wr_data(wd_a[1]), .rd_data(rd_a[1]),
    .status_byte(st_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .ncs_spi(ncs_a[1]), .sck_spi(sck_a[1]), .mosi_spi(mosi_a[1]),
    .miso_spi(miso_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] mosi_cap;
    logic [31:0] rd;
    logic [7:0]  st;
    int          sck_cnt;
    int          done_cyc;
    int          done_cnt;
    int          busy_fall;
    int          viol;
    logic        ncs1;
    logic        mosi1;
    logic        timeout;
    logic        ab_ncs;
    logic        ab_sck;
    logic        ab_busy;
    logic        ab_done;
    logic [31:0] ab_rd;
    logic [7:0]  ab_st;
  } fr_t;

  typedef struct {
    int          u;
    logic [7:0]  c;
    logic [2:0]  len;
    logic [31:0] wd;
    logic [39:0] sl;
    logic [39:0] e_mosi;
    logic [31:0] e_rd;
    logic [7:0]  e_st;
    int          e_sck;
    int          e_done;
    int          e_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // Reference frame: command byte then the low len bytes of word, MSB first,
  // left-aligned in a 40-bit stream.
  function automatic logic [39:0] stream_of(input logic [7:0] first, input int l, input logic [31:0] word);
    logic [39:0] s;
    s = {first, 32'h0};
    for (int j = 0; j < l; j++) s[31 - 8*j -: 8] = word[8*(l-1-j) +: 8];
    return s;
  endfunction

  // Drives one frame on unit u and plays the slave: sl is the bit stream the
  // slave returns (left-aligned). poke_cyc: cycle at which a stray start with
  // cmd=FF is pulsed. abort_rise: SCK rise count at which rst is pulsed.
  task automatic run_frame(input int u, input logic [7:0] c, input logic [2:0] len,
                           input logic [31:0] wd, input logic [39:0] sl,
                           input int poke_cyc, input int abort_rise, output fr_t r);
    int cyc, rises, falls;
    logic prev_sck;
    r = '0;
    r.timeout = 1'b1;
    @(posedge clk); #1;
    cmd_a[u] = c; len_a[u] = len; wd_a[u] = wd; miso_a[u] = sl[39]; start_a[u] = 1'b1;
    @(posedge clk); #1;
    start_a[u] = 1'b0;
    cyc = 1; rises = 0; falls = 0; prev_sck = 1'b0;
    while (cyc < 2000) begin
      if (cyc == 1) begin r.ncs1 = ncs_a[u]; r.mosi1 = mosi_a[u]; end
      if (cyc == poke_cyc) begin start_a[u] = 1'b1; cmd_a[u] = 8'hFF; end
      else if (cyc == poke_cyc + 1) begin start_a[u] = 1'b0; cmd_a[u] = c; end
      if (sck_a[u] && ncs_a[u]) r.viol++;
      if (sck_a[u] && !prev_sck) begin
        if (rises < 40) r.mosi_cap[39 - rises] = mosi_a[u];
        rises++;
        if (rises == abort_rise) begin
          rst_a[u] = 1'b1;
          #1;
          r.ab_ncs = ncs_a[u]; r.ab_sck = sck_a[u]; r.ab_busy = busy_a[u];
          r.ab_done = done_a[u]; r.ab_rd = rd_a[u]; r.ab_st = st_a[u];
          #1;
          rst_a[u] = 1'b0;
          repeat (20) begin
            @(posedge clk); #1;
            if (done_a[u]) r.done_cnt++;
          end
          r.timeout = 1'b0;
          r.sck_cnt = rises;
          return;
        end
      end
      if (!sck_a[u] && prev_sck) begin
        falls++;
        miso_a[u] = (falls < 40) ? sl[39 - falls] : 1'b0;
      end
      if (done_a[u]) begin
        if (r.done_cnt == 0) r.done_cyc = cyc;
        r.done_cnt++;
      end
      if (!busy_a[u]) begin
        r.busy_fall = cyc;
        r.timeout = 1'b0;
        break;
      end
      prev_sck = sck_a[u];
      @(posedge clk); #1;
      cyc++;
    end
    r.sck_cnt = rises;
    r.rd = rd_a[u];
    r.st = st_a[u];
  endtask

  task automatic check_frame(input string tag, input fr_t r, input logic [7:0] c,
                             input logic [39:0] e_mosi, input logic [31:0] e_rd,
                             input logic [7:0] e_st, input int e_sck, input int e_done,
                             input int e_busy);
    int f0;
    f0 = n_fail;
    chk(tag, "timeout",    64'(r.timeout), 64'd0);
    chk(tag, "ncs_cyc1",   64'(r.ncs1), 64'd0);
    chk(tag, "mosi_cyc1",  64'(r.mosi1), 64'(c[7]));
    chk(tag, "mosi_stream", 64'(r.mosi_cap), 64'(e_mosi));
    chk(tag, "sck_pulses", 64'(r.sck_cnt), 64'(e_sck));
    chk(tag, "done_cycle", 64'(r.done_cyc), 64'(e_done));
    chk(tag, "done_count", 64'(r.done_cnt), 64'd1);
    chk(tag, "busy_fall",  64'(r.busy_fall), 64'(e_busy));
    chk(tag, "sck_while_ncs_high", 64'(r.viol), 64'd0);
    chk(tag, "rd_data",    64'(r.rd), 64'(e_rd));
    chk(tag, "status_byte", 64'(r.st), 64'(e_st));
    $display("[TB] %s cmd=%02h mosi=%010h rd=%08h st=%02h done@%0d busy_low@%0d errors=%0d",
             tag, c, r.mosi_cap, r.rd, r.st, r.done_cyc, r.busy_fall, n_fail - f0);
  endtask

  initial begin
    fr_t r;
    int  guard;
    for (int u = 0; u < 2; u++) begin
      rst_a[u] = 1'b1; start_a[u] = 1'b0; miso_a[u] = 1'b0;
      cmd_a[u] = '0; len_a[u] = '0; wd_a[u] = '0;
    end

    vecs[0] = '{0, 8'h80, 3'd4, 32'hDEADBEEF, 40'h91_0000_0000, 40'h80_DEAD_BEEF, 32'h0000_0000, 8'h91, 40, 163, 165};
    vecs[1] = '{0, 8'h02, 3'd4, 32'h0000_0000, 40'h91_1234_5678, 40'h02_0000_0000, 32'h1234_5678, 8'h91, 40, 163, 165};
    vecs[2] = '{0, 8'h03, 3'd2, 32'hAAAA_5555, 40'hA5_1234_0000, 40'h03_5555_0000, 32'h0000_1234, 8'hA5, 24, 99, 101};
    vecs[3] = '{0, 8'h05, 3'd0, 32'hFFFF_FFFF, 40'h3C_0000_0000, 40'h05_0000_0000, 32'h0000_0000, 8'h3C, 8, 35, 37};
    vecs[4] = '{0, 8'h81, 3'd7, 32'h0102_0304, 40'h7E_CAFE_F00D, 40'h81_0102_0304, 32'hCAFE_F00D, 8'h7E, 40, 163, 165};
    vecs[5] = '{1, 8'h42, 3'd1, 32'h0000_00A7, 40'h91_5A00_0000, 40'h42_A700_0000, 32'h0000_005A, 8'h91, 16, 34, 35};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset", "ncs_sck_mosi_busy_done",
          64'({ncs_a[u], sck_a[u], mosi_a[u], busy_a[u], done_a[u]}), 64'(5'b10000));
      chk("reset", "rd_data", 64'(rd_a[u]), 64'd0);
      chk("reset", "status_byte", 64'(st_a[u]), 64'd0);
    end
    $display("[TB] reset state checked");

    // Start held across reset release is taken on the first edge
    start_a[0] = 1'b1;
    #2;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    @(posedge clk); #1;
    chk("first_edge", "ncs_after_first_edge", 64'(ncs_a[0]), 64'd0);
    start_a[0] = 1'b0;
    guard = 0;
    while (busy_a[0] && guard < 500) begin @(posedge clk); #1; guard++; end
    chk("first_edge", "frame_ends", 64'(busy_a[0]), 64'd0);
    $display("[TB] first_edge frame ncs low after first edge, ended after %0d cycles", guard);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].u, vecs[i].c, vecs[i].len, vecs[i].wd, vecs[i].sl, -10, -1, r);
      check_frame($sformatf("vec%0d", i), r, vecs[i].c, vecs[i].e_mosi, vecs[i].e_rd,
                  vecs[i].e_st, vecs[i].e_sck, vecs[i].e_done, vecs[i].e_busy);
    end

    // Back-to-back on the CLK_DIV=1 unit: busy falls at cycle 35; a start held
    // from then on is taken at cycle 36, so ncs falls at cycle 37.
    run_frame(1, 8'h42, 3'd1, 32'h0000_00A7, 40'h91_5A00_0000, -10, -1, r);
    check_frame("b2b_first", r, 8'h42, 40'h42_A700_0000, 32'h0000_005A, 8'h91, 16, 34, 35);
    cmd_a[1] = 8'h11; len_a[1] = 3'd0; start_a[1] = 1'b1;
    @(posedge clk); #1;
    chk("b2b", "ncs_cycle36", 64'(ncs_a[1]), 64'd1);
    @(posedge clk); #1;
    chk("b2b", "ncs_cycle37", 64'(ncs_a[1]), 64'd0);
    start_a[1] = 1'b0;
    guard = 0;
    while (busy_a[1] && guard < 500) begin @(posedge clk); #1; guard++; end
    chk("b2b", "second_frame_ends", 64'(busy_a[1]), 64'd0);
    $display("[TB] b2b second frame accepted one cycle after busy fell");

    // Stray start mid-frame is ignored
    run_frame(0, 8'h80, 3'd4, 32'hDEADBEEF, 40'h91_0000_0000, 10, -1, r);
    check_frame("ignored_start", r, 8'h80, 40'h80_DEAD_BEEF, 32'h0, 8'h91, 40, 163, 165);

    // Reset between the 12th SCK rise and fall
    run_frame(0, 8'h02, 3'd4, 32'h0, 40'h91_1234_5678, -10, 12, r);
    chk("abort", "ncs",         64'(r.ab_ncs), 64'd1);
    chk("abort", "sck",         64'(r.ab_sck), 64'd0);
    chk("abort", "busy",        64'(r.ab_busy), 64'd0);
    chk("abort", "done",        64'(r.ab_done), 64'd0);
    chk("abort", "done_pulses", 64'(r.done_cnt), 64'd0);
    chk("abort", "rd_data",     64'(r.ab_rd), 64'd0);
    chk("abort", "status_byte", 64'(r.ab_st), 64'd0);
    $display("[TB] abort at rise %0d ncs=%0b sck=%0b busy=%0b done_pulses=%0d",
             r.sck_cnt, r.ab_ncs, r.ab_sck, r.ab_busy, r.done_cnt);
    run_frame(0, 8'h02, 3'd4, 32'h0, 40'h91_1234_5678, -10, -1, r);
    check_frame("after_abort", r, 8'h02, 40'h02_0000_0000, 32'h1234_5678, 8'h91, 40, 163, 165);

    // Results stay put while idle
    repeat (5) @(posedge clk);
    #1;
    chk("hold", "rd_data", 64'(rd_a[0]), 64'h1234_5678);
    chk("hold", "status_byte", 64'(st_a[0]), 64'h91);

    // Randomized frames against the reference rules
    for (int i = 0; i < 24; i++) begin
      int u, l, b, d;
      logic [7:0]  c, s;
      logic [2:0]  len;
      logic [31:0] wd, p, e_rd;
      c   = 8'($urandom);
      s   = 8'($urandom);
      len = 3'($urandom_range(0, 7));
      wd  = $urandom;
      p   = $urandom;
      u   = i % 2;
      d   = (u == 0) ? DIV0 : DIV1;
      l   = (len > 4) ? 4 : int'(len);
      b   = 8 + 8 * l;
      e_rd = '0;
      for (int j = 0; j < l; j++) e_rd[8*j +: 8] = p[8*j +: 8];
      run_frame(u, c, len, wd, stream_of(s, l, p), -10, -1, r);
      check_frame($sformatf("rand%0d_u%0d_len%0d", i, u, len), r, c, stream_of(c, l, wd),
                  e_rd, s, b, 1 + (2*b + 1) * d, 1 + (2*b + 2) * d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
